// File: rtl/data_receiver.sv
// Byte-to-word deserializer: packs BYTES_PER_WORD bytes (MSB first) into a word,
// strobes it out for one cycle and drops partial words on idle timeout or flush.
module data_receiver #(
  parameter int BYTE_WIDTH     = 8,
  parameter int BYTES_PER_WORD = 4,
  parameter int TIMEOUT_CYCLES = 1000,
  parameter int COUNT_WIDTH    = 16
) (
  input  logic                                 clk_i,
  input  logic                                 rst_n_i,
  input  logic [BYTE_WIDTH-1:0]                in_data_i,
  input  logic                                 in_data_ready_i,
  input  logic                                 flush_i,
  output logic [BYTE_WIDTH*BYTES_PER_WORD-1:0] out_data_o,
  output logic                                 out_data_ready_o,
  output logic                                 busy_o,
  output logic                                 frame_error_o,
  output logic [COUNT_WIDTH-1:0]               word_count_o
);

  // state   | meaning
  // IDLE    | no partial word held, idle timer frozen at 0
  // COLLECT | 1..BYTES_PER_WORD-1 bytes held, idle timer running

  localparam int WORD_W = BYTE_WIDTH * BYTES_PER_WORD;
  localparam int LOW_W  = WORD_W - BYTE_WIDTH;
  localparam int CNT_W  = $clog2(BYTES_PER_WORD);
  localparam int TMR_W  = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam bit TIMEOUT_EN = (TIMEOUT_CYCLES > 0);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BYTES_PER_WORD - 1);
  // Expiry is detected one count early so a strobe on that edge can still win.
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  typedef enum logic {IDLE, COLLECT} state_t;

  state_t                   state_q, state_d;
  logic [WORD_W-1:0]        shift_q, shift_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic [TMR_W-1:0]         tmr_q, tmr_d;
  logic [WORD_W-1:0]        out_q, out_d;
  logic                     rdy_q, rdy_d;
  logic                     ferr_q, ferr_d;
  logic [COUNT_WIDTH-1:0]   wc_q, wc_d;
  logic [WORD_W-1:0]        shifted;

  assign shifted = {shift_q[LOW_W-1:0], in_data_i};

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
      shift_q <= '0;
      cnt_q   <= '0;
      tmr_q   <= '0;
      out_q   <= '0;
      rdy_q   <= 1'b0;
      ferr_q  <= 1'b0;
      wc_q    <= '0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      tmr_q   <= tmr_d;
      out_q   <= out_d;
      rdy_q   <= rdy_d;
      ferr_q  <= ferr_d;
      wc_q    <= wc_d;
    end
  end

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    cnt_d   = cnt_q;
    tmr_d   = tmr_q;
    out_d   = out_q;
    rdy_d   = 1'b0;
    ferr_d  = 1'b0;
    wc_d    = wc_q;

    if (flush_i) begin
      if (state_q == COLLECT) begin
        state_d = IDLE;
        shift_d = '0;
        cnt_d   = '0;
        tmr_d   = '0;
      end
    end else if (in_data_ready_i) begin
      shift_d = shifted;
      tmr_d   = '0;
      if (cnt_q == CNT_LAST) begin
        state_d = IDLE;
        cnt_d   = '0;
        out_d   = shifted;
        rdy_d   = 1'b1;
        wc_d    = wc_q + 1'b1;
      end else begin
        state_d = COLLECT;
        cnt_d   = cnt_q + 1'b1;
      end
    end else if (state_q == COLLECT) begin
      if (TIMEOUT_EN && tmr_q == TMR_LAST) begin
        state_d = IDLE;
        shift_d = '0;
        cnt_d   = '0;
        tmr_d   = '0;
        ferr_d  = 1'b1;
      end else if (tmr_q != '1) begin
        tmr_d = tmr_q + 1'b1;
      end
    end
  end

  assign out_data_o       = out_q;
  assign out_data_ready_o = rdy_q;
  assign busy_o           = (state_q == COLLECT);
  assign frame_error_o    = ferr_q;
  assign word_count_o     = wc_q;

endmodule

// File: tb/tb_data_receiver.sv
// Directed bench for data_receiver: vector table for framing/flush, hand-written
// sequences for timeout edges and asynchronous reset.
module tb_data_receiver;

  logic        clk;
  logic        rst_n;
  logic [7:0]  in_data;
  logic        in_data_ready;
  logic        flush;
  logic [31:0] out_data;
  logic        out_data_ready;
  logic        busy;
  logic        frame_error;
  logic [15:0] word_count;

  int n_cmp = 0;
  int n_err = 0;

  data_receiver #(
    .BYTE_WIDTH(8), .BYTES_PER_WORD(4), .TIMEOUT_CYCLES(10), .COUNT_WIDTH(16)
  ) dut (
    .clk_i(clk), .rst_n_i(rst_n), .in_data_i(in_data), .in_data_ready_i(in_data_ready),
    .flush_i(flush), .out_data_o(out_data), .out_data_ready_o(out_data_ready),
    .busy_o(busy), .frame_error_o(frame_error), .word_count_o(word_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        stb;
    logic [7:0]  d;
    logic        fl;
    logic        rdy;
    logic [31:0] out;
    logic        busy;
    logic        ferr;
    logic [15:0] wc;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(logic stb, logic [7:0] d, logic fl, logic rdy,
                              logic [31:0] out, logic bsy, logic ferr, logic [15:0] wc);
    vec_t v;
    v.stb = stb; v.d = d; v.fl = fl; v.rdy = rdy;
    v.out = out; v.busy = bsy; v.ferr = ferr; v.wc = wc;
    vecs.push_back(v);
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_all(string tag, logic rdy, logic [31:0] out, logic bsy,
                           logic ferr, logic [15:0] wc);
    check({tag, " rdy"},  {31'd0, out_data_ready}, {31'd0, rdy});
    check({tag, " out"},  out_data, out);
    check({tag, " busy"}, {31'd0, busy}, {31'd0, bsy});
    check({tag, " ferr"}, {31'd0, frame_error}, {31'd0, ferr});
    check({tag, " wc"},   {16'd0, word_count}, {16'd0, wc});
  endtask

  task automatic cyc(logic stb, logic [7:0] d, logic fl);
    @(negedge clk);
    in_data_ready = stb;
    in_data       = d;
    flush         = fl;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; in_data = '0; in_data_ready = 1'b0; flush = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_all("reset", 1'b0, 32'h0, 1'b0, 1'b0, 16'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // stb d fl | rdy out busy ferr wc
    add(1, 8'h12, 0, 0, 32'h0,        1, 0, 0);
    add(1, 8'h34, 0, 0, 32'h0,        1, 0, 0);
    add(1, 8'h56, 0, 0, 32'h0,        1, 0, 0);
    add(1, 8'h78, 0, 1, 32'h12345678, 0, 0, 1);
    add(1, 8'hDE, 0, 0, 32'h12345678, 1, 0, 1);
    add(1, 8'hAD, 0, 0, 32'h12345678, 1, 0, 1);
    add(1, 8'hBE, 0, 0, 32'h12345678, 1, 0, 1);
    add(1, 8'hEF, 0, 1, 32'hDEADBEEF, 0, 0, 2);
    add(1, 8'h01, 0, 0, 32'hDEADBEEF, 1, 0, 2);
    add(1, 8'h02, 0, 0, 32'hDEADBEEF, 1, 0, 2);
    add(1, 8'h03, 0, 0, 32'hDEADBEEF, 1, 0, 2);
    add(1, 8'h04, 0, 1, 32'h01020304, 0, 0, 3);
    add(0, 8'h00, 0, 0, 32'h01020304, 0, 0, 3);
    add(1, 8'h01, 0, 0, 32'h01020304, 1, 0, 3);
    add(1, 8'h02, 0, 0, 32'h01020304, 1, 0, 3);
    add(1, 8'h03, 1, 0, 32'h01020304, 0, 0, 3);
    add(1, 8'h10, 0, 0, 32'h01020304, 1, 0, 3);
    add(1, 8'h20, 0, 0, 32'h01020304, 1, 0, 3);
    add(1, 8'h30, 0, 0, 32'h01020304, 1, 0, 3);
    add(1, 8'h40, 0, 1, 32'h10203040, 0, 0, 4);
    add(0, 8'h00, 1, 0, 32'h10203040, 0, 0, 4);
    add(1, 8'h99, 1, 0, 32'h10203040, 0, 0, 4);
    add(1, 8'hA1, 0, 0, 32'h10203040, 1, 0, 4);
    add(1, 8'hB2, 0, 0, 32'h10203040, 1, 0, 4);
    add(1, 8'hC3, 0, 0, 32'h10203040, 1, 0, 4);
    add(1, 8'hD4, 0, 1, 32'hA1B2C3D4, 0, 0, 5);

    foreach (vecs[i]) begin
      cyc(vecs[i].stb, vecs[i].d, vecs[i].fl);
      check_all($sformatf("vec%0d", i), vecs[i].rdy, vecs[i].out, vecs[i].busy,
                vecs[i].ferr, vecs[i].wc);
    end

    // Timeout after 10 idle cycles drops the partial word.
    cyc(1, 8'hAA, 0);
    cyc(1, 8'hBB, 0);
    for (int i = 1; i <= 10; i++) begin
      cyc(0, 8'h00, 0);
      check($sformatf("to idle%0d ferr", i), {31'd0, frame_error}, {31'd0, (i == 10)});
      check($sformatf("to idle%0d busy", i), {31'd0, busy}, {31'd0, (i != 10)});
    end
    cyc(0, 8'h00, 0);
    check("to ferr one-shot", {31'd0, frame_error}, 32'd0);
    cyc(1, 8'h11, 0);
    cyc(1, 8'h22, 0);
    cyc(1, 8'h33, 0);
    check("to no early word", {31'd0, out_data_ready}, 32'd0);
    cyc(1, 8'h44, 0);
    check_all("to after", 1'b1, 32'h11223344, 1'b0, 1'b0, 16'd6);

    // Nine idle cycles, then strobes on the would-be expiry edge: no error.
    cyc(1, 8'hAA, 0);
    for (int i = 1; i <= 9; i++) begin
      cyc(0, 8'h00, 0);
      check($sformatf("near idle%0d ferr", i), {31'd0, frame_error}, 32'd0);
    end
    cyc(1, 8'hBB, 0);
    check("near edge ferr", {31'd0, frame_error}, 32'd0);
    check("near edge busy", {31'd0, busy}, 32'd1);
    cyc(1, 8'hCC, 0);
    cyc(1, 8'hDD, 0);
    check_all("near after", 1'b1, 32'hAABBCCDD, 1'b0, 1'b0, 16'd7);

    // Asynchronous reset mid-word.
    cyc(1, 8'h01, 0);
    cyc(1, 8'h02, 0);
    cyc(1, 8'h03, 0);
    cyc(0, 8'h00, 0);
    #2;
    rst_n = 1'b0;
    #1;
    check_all("async rst", 1'b0, 32'h0, 1'b0, 1'b0, 16'd0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc(1, 8'h04, 0);
    cyc(1, 8'h05, 0);
    cyc(1, 8'h06, 0);
    cyc(1, 8'h07, 0);
    check_all("post rst", 1'b1, 32'h04050607, 1'b0, 1'b0, 16'd1);
    cyc(0, 8'h00, 0);
    check("post rst rdy drop", {31'd0, out_data_ready}, 32'd0);
    check("post rst hold", out_data, 32'h04050607);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
